// File: rtl/signal_phase_scheduler.sv
// Round-robin phase scheduler: grants one of 32 requesters for a tick-timed dwell,
// then inserts a tick-timed all-red clearance before the next arbitration.
module signal_phase_scheduler #(
  parameter int unsigned DWELL_TICKS = 8,
  parameter int unsigned CLEAR_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tick,
  input  logic [31:0] req,
  output logic [4:0]  sel,
  output logic        sel_valid,
  output logic        clearing,
  output logic        phase_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t      state_q;
  logic [4:0]  sel_q;
  logic [4:0]  last_q;
  logic [7:0]  cnt_q;
  logic        sel_valid_q;
  logic        clearing_q;
  logic        phase_done_q;

  logic [5:0]  pick_s;
  logic        other_req_s;

  // Bit 5 flags a winner; the lowest offset from last+1 wins, last itself is searched last.
  function automatic logic [5:0] rr_pick(input logic [31:0] r, input logic [4:0] last);
    logic [5:0] res;
    logic [4:0] idx;
    res = 6'd0;
    for (int k = 32; k >= 1; k--) begin
      idx = last + 5'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Arbitration result and the competing-request test used at grant expiry
  always_comb begin
    pick_s      = rr_pick(req, last_q);
    other_req_s = |(req & ~(32'h0000_0001 << sel_q));
  end

  // Scheduler FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= 5'd0;
      last_q       <= 5'd31;
      cnt_q        <= 8'd0;
      sel_valid_q  <= 1'b0;
      clearing_q   <= 1'b0;
      phase_done_q <= 1'b0;
    end else begin
      phase_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          clearing_q <= 1'b0;
          if (pick_s[5]) begin
            state_q     <= ST_GRANT;
            sel_q       <= pick_s[4:0];
            last_q      <= pick_s[4:0];
            cnt_q       <= 8'(DWELL_TICKS);
            sel_valid_q <= 1'b1;
          end else begin
            sel_valid_q <= 1'b0;
          end
        end
        ST_GRANT: begin
          if (tick) begin
            if (cnt_q == 8'd1) begin
              // Extend only when the holder still wants it and nobody else is waiting
              if (!other_req_s && req[sel_q]) begin
                cnt_q <= 8'(DWELL_TICKS);
              end else begin
                state_q     <= ST_CLEAR;
                cnt_q       <= 8'(CLEAR_TICKS);
                sel_valid_q <= 1'b0;
                clearing_q  <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        ST_CLEAR: begin
          if (tick) begin
            if (cnt_q == 8'd1) begin
              state_q      <= ST_IDLE;
              cnt_q        <= 8'd0;
              clearing_q   <= 1'b0;
              phase_done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= 8'd0;
          sel_valid_q <= 1'b0;
          clearing_q  <= 1'b0;
        end
      endcase
    end
  end

  assign sel        = sel_q;
  assign sel_valid  = sel_valid_q;
  assign clearing   = clearing_q;
  assign phase_done = phase_done_q;

endmodule

// File: tb/tb_signal_phase_scheduler.sv
// Bench for signal_phase_scheduler: directed scenarios plus random traffic, all
// cycle-checked against a behavioural reference of the scheduling rules.
module tb_signal_phase_scheduler;

  localparam int DWELL = 8;
  localparam int CLR   = 2;

  logic        clk = 1'b0;
  logic        reset_n, tick;
  logic [31:0] req;
  logic [4:0]  sel;
  logic        sel_valid, clearing, phase_done;

  logic        rst3_n, tick3;
  logic [31:0] req3;
  logic [4:0]  sel3;
  logic        sel_valid3, clearing3, phase_done3;

  int n_tests = 0;
  int n_fail  = 0;

  signal_phase_scheduler #(.DWELL_TICKS(DWELL), .CLEAR_TICKS(CLR)) u_dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .req(req),
    .sel(sel), .sel_valid(sel_valid), .clearing(clearing), .phase_done(phase_done)
  );

  signal_phase_scheduler #(.DWELL_TICKS(3), .CLEAR_TICKS(2)) u_dut3 (
    .clk(clk), .reset_n(rst3_n), .tick(tick3), .req(req3),
    .sel(sel3), .sel_valid(sel_valid3), .clearing(clearing3), .phase_done(phase_done3)
  );

  always #5 clk = ~clk;

  // Reference: the light is either idle, green for a requester, or all-red.
  localparam int M_IDLE = 0, M_GREEN = 1, M_RED = 2;
  int          m_mode = M_IDLE;
  int          m_sel  = 0;
  int          m_last = 31;
  int          m_left = 0;
  bit          m_done = 1'b0;

  int          wait_ph[32];
  bit          prev_valid = 1'b0;
  int          grants[$];

  function automatic int next_winner(input logic [31:0] rq, input int last);
    for (int k = 1; k <= 32; k++) begin
      if (rq[(last + k) % 32]) return (last + k) % 32;
    end
    return -1;
  endfunction

  task automatic model_update(input logic [31:0] rq, input logic tk, input logic rn);
    logic [31:0] others;
    if (!rn) begin
      m_mode = M_IDLE; m_sel = 0; m_last = 31; m_left = 0; m_done = 1'b0;
      return;
    end
    m_done = 1'b0;
    if (m_mode == M_IDLE) begin
      if (rq != 32'h0) begin
        m_sel  = next_winner(rq, m_last);
        m_last = m_sel;
        m_mode = M_GREEN;
        m_left = DWELL;
      end
    end else if (tk) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        others = rq;
        others[m_sel] = 1'b0;
        if (m_mode == M_GREEN && others == 32'h0 && rq[m_sel]) begin
          m_left = DWELL;
        end else if (m_mode == M_GREEN) begin
          m_mode = M_RED;
          m_left = CLR;
        end else begin
          m_mode = M_IDLE;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] rq, input logic tk, input logic rn);
    int worst;
    req = rq; tick = tk; reset_n = rn;
    model_update(rq, tk, rn);
    @(posedge clk);
    #1;
    chk("sel",        {27'd0, sel},          32'(m_sel));
    chk("sel_valid",  {31'd0, sel_valid},    {31'd0, m_mode == M_GREEN});
    chk("clearing",   {31'd0, clearing},     {31'd0, m_mode == M_RED});
    chk("phase_done", {31'd0, phase_done},   {31'd0, m_done});
    chk("mutex",      {31'd0, sel_valid & clearing}, 32'd0);
    // Count grant phases each still-requesting requester has been passed over
    worst = 0;
    for (int i = 0; i < 32; i++) if (!rq[i] || !rn) wait_ph[i] = 0;
    if (sel_valid === 1'b1 && !prev_valid) begin
      grants.push_back(int'(sel));
      for (int i = 0; i < 32; i++) begin
        if (i == int'(sel)) wait_ph[i] = 0;
        else if (rq[i]) wait_ph[i]++;
        if (wait_ph[i] > worst) worst = wait_ph[i];
      end
      chk("starvation", {31'd0, worst <= 32}, 32'd1);
    end
    prev_valid = (sel_valid === 1'b1);
  endtask

  initial begin
    int gl, tk_cnt, guard, cyc, dones;
    logic [31:0] rq;
    for (int i = 0; i < 32; i++) wait_ph[i] = 0;
    rst3_n = 1'b0; tick3 = 1'b0; req3 = 32'h0;

    // Reset state
    step(32'h0, 1'b1, 1'b0);
    chk("rst_sel", {27'd0, sel}, 32'd0);
    chk("rst_valid", {31'd0, sel_valid}, 32'd0);

    // Basic grant with extension and no gap
    for (int c = 1; c <= 12; c++) begin
      step(32'h0000_0001, 1'b1, 1'b1);
      chk("basic_valid", {31'd0, sel_valid}, 32'd1);
      chk("basic_nogap", {31'd0, clearing}, 32'd0);
    end

    // Round-robin wrap: 0,31,0,31 with three done pulses between
    step(32'h0, 1'b1, 1'b0);
    grants.delete();
    dones = 0;
    for (int c = 0; c < 41; c++) begin
      step(32'h8000_0001, 1'b1, 1'b1);
      if (phase_done === 1'b1) dones++;
    end
    chk("wrap_count", 32'(grants.size()), 32'd4);
    if (grants.size() == 4) begin
      chk("wrap_g0", 32'(grants[0]), 32'd0);
      chk("wrap_g1", 32'(grants[1]), 32'd31);
      chk("wrap_g2", 32'(grants[2]), 32'd0);
      chk("wrap_g3", 32'(grants[3]), 32'd31);
    end
    chk("wrap_dones", 32'(dones), 32'd3);

    // Early release of index 5 keeps the full dwell
    step(32'h0, 1'b1, 1'b0);
    step(32'h0000_0020, 1'b1, 1'b1);
    chk("early_sel", {27'd0, sel}, 32'd5);
    step(32'h0000_0020, 1'b1, 1'b1);
    for (int c = 3; c <= 8; c++) begin
      step(32'h0, 1'b1, 1'b1);
      chk("early_green", {31'd0, sel_valid}, 32'd1);
    end
    for (int c = 0; c < 2; c++) begin
      step(32'h0, 1'b1, 1'b1);
      chk("early_clear", {31'd0, clearing}, 32'd1);
    end
    step(32'h0, 1'b1, 1'b1);
    chk("early_done", {31'd0, phase_done}, 32'd1);
    chk("early_idle", {30'd0, sel_valid, clearing}, 32'd0);
    step(32'h0, 1'b1, 1'b1);
    chk("early_done_once", {31'd0, phase_done}, 32'd0);

    // Reset during a grant of index 12
    step(32'h0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) step(32'h0000_1000, 1'b1, 1'b1);
    chk("mid_sel12", {27'd0, sel}, 32'd12);
    step(32'h0000_1000, 1'b1, 1'b0);
    chk("mid_rst", {26'd0, sel, sel_valid, clearing}, 32'd0);
    step(32'h0000_1000, 1'b1, 1'b1);
    chk("mid_regrant", {26'd0, sel, sel_valid}, {26'd0, 5'd12, 1'b1});

    // Tick every 4th cycle with a 3-tick dwell, for each tick phase
    for (int off = 0; off < 4; off++) begin
      rst3_n = 1'b0; req3 = 32'h0; tick3 = 1'b0;
      step(32'h0, 1'b0, 1'b1);
      rst3_n = 1'b1; req3 = 32'h0000_0080; tick3 = (off == 0);
      step(32'h0, 1'b0, 1'b1);
      chk("gate_enter", {26'd0, sel3, sel_valid3}, {26'd0, 5'd7, 1'b1});
      req3 = 32'h0; cyc = 1; gl = 0; tk_cnt = 0; guard = 0;
      while (sel_valid3 === 1'b1 && guard < 40) begin
        tick3 = ((cyc % 4) == off);
        if (tick3) tk_cnt++;
        gl++; cyc++; guard++;
        step(32'h0, 1'b0, 1'b1);
      end
      chk("gate_ticks", 32'(tk_cnt), 32'd3);
      chk("gate_len", 32'(gl), 32'((off == 0 ? 4 : off) + 8));
      chk("gate_clear", {31'd0, clearing3}, 32'd1);
    end

    // Random traffic against the reference model
    step(32'h0, 1'b1, 1'b0);
    for (int c = 0; c < 10000; c++) begin
      case ($urandom_range(0, 3))
        0: rq = 32'h0;
        1: rq = 32'h1 << $urandom_range(0, 31);
        2: rq = $urandom & $urandom & $urandom;
        default: rq = $urandom;
      endcase
      step(rq, ($urandom_range(0, 2) != 0), ($urandom_range(0, 499) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
